row_select_sequencer: RTL and testbench

//  Parametrised, registered row-select decoder for the memory array.

---
 rtl/row_select_sequencer_if.sv | 31 +++
 rtl/row_select_sequencer.sv | 136 +++++++++++++
 tb/tb_row_select_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/row_select_sequencer_if.sv
// Request/row-enable bundle between the access controller and the row
// select sequencer. The requester drives the master side and the sequencer
// implements the slave side.
interface row_select_sequencer_if #(
  parameter int ADDR_W    = 3,
  parameter int NUM_ROWS  = 8,
  parameter int MAX_BURST = 8
);
  localparam int BL_W = $clog2(MAX_BURST) + 1;

  logic                req;
  logic [ADDR_W-1:0]   start_address;
  logic [BL_W-1:0]     burst_len;
  logic                stall;
  logic [NUM_ROWS-1:0] decoded_address;
  logic [ADDR_W-1:0]   current_address;
  logic                row_valid;
  logic                busy;
  logic                done;
  logic                addr_err;

  modport master (
    output req, start_address, burst_len, stall,
    input  decoded_address, current_address, row_valid, busy, done, addr_err
  );

  modport slave (
    input  req, start_address, burst_len, stall,
    output decoded_address, current_address, row_valid, busy, done, addr_err
  );
endinterface

// File: rtl/row_select_sequencer.sv
// Registered row-select decoder: turns an accepted request (start row plus
// burst length) into a one-hot row enable, then walks consecutive rows with
// wrap at NUM_ROWS. Stall freezes the current row; out-of-range starts are
// flagged and never enable a row.
module row_select_sequencer #(
  parameter int ADDR_W    = 3,
  parameter int NUM_ROWS  = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  row_select_sequencer_if.slave   bus
);
  localparam int BL_W = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} state_t;

  state_t              state, state_nx;
  logic [NUM_ROWS-1:0] dec_q, dec_nx;
  logic [ADDR_W-1:0]   cur_q, cur_nx;
  logic [BL_W-1:0]     rem_q, rem_nx;
  logic                valid_q, valid_nx;
  logic                busy_q, busy_nx;
  logic                done_q, done_nx;
  logic                err_q, err_nx;

  logic [BL_W-1:0]     eff_len;
  logic                in_range;
  logic [ADDR_W-1:0]   cur_step;

  // Burst length clamp and start-address range check on the request inputs.
  always_comb begin
    eff_len = bus.burst_len;
    if (bus.burst_len == '0)
      eff_len = BL_W'(1);
    else if (32'(bus.burst_len) > MAX_BURST)
      eff_len = BL_W'(MAX_BURST);
    in_range = 32'(bus.start_address) < NUM_ROWS;
    cur_step = (cur_q == ADDR_W'(NUM_ROWS - 1)) ? '0 : cur_q + ADDR_W'(1);
  end

  // Next-state and next-output computation; every output is a register.
  always_comb begin
    state_nx = state;
    dec_nx   = dec_q;
    cur_nx   = cur_q;
    rem_nx   = rem_q;
    valid_nx = valid_q;
    busy_nx  = busy_q;
    done_nx  = done_q;
    err_nx   = err_q;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          busy_nx = 1'b1;
          if (in_range) begin
            state_nx = ACTIVE;
            dec_nx   = NUM_ROWS'(1) << bus.start_address;
            cur_nx   = bus.start_address;
            valid_nx = 1'b1;
            err_nx   = 1'b0;
            rem_nx   = eff_len - BL_W'(1);
          end else begin
            state_nx = FINISH;
            dec_nx   = '0;
            cur_nx   = '0;
            valid_nx = 1'b0;
            done_nx  = 1'b1;
            err_nx   = 1'b1;
            rem_nx   = '0;
          end
        end
      end
      ACTIVE: begin
        if (!bus.stall) begin
          if (rem_q != '0) begin
            dec_nx = NUM_ROWS'(1) << cur_step;
            cur_nx = cur_step;
            rem_nx = rem_q - BL_W'(1);
          end else begin
            state_nx = FINISH;
            dec_nx   = '0;
            cur_nx   = '0;
            valid_nx = 1'b0;
            done_nx  = 1'b1;
          end
        end
      end
      FINISH: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        rem_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        dec_nx   = '0;
        cur_nx   = '0;
        rem_nx   = '0;
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dec_q   <= '0;
      cur_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      dec_q   <= dec_nx;
      cur_q   <= cur_nx;
      rem_q   <= rem_nx;
      valid_q <= valid_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      err_q   <= err_nx;
    end
  end

  assign bus.decoded_address = dec_q;
  assign bus.current_address = cur_q;
  assign bus.row_valid       = valid_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.addr_err        = err_q;
endmodule

// File: tb/tb_row_select_sequencer.sv
// Directed bench for row_select_sequencer: an 8-row instance covers single,
// wrap, stall, clamp and reset cases; a 6-row instance covers range errors.
module tb_row_select_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  row_select_sequencer_if #(.ADDR_W(3), .NUM_ROWS(8), .MAX_BURST(8)) b8 ();
  row_select_sequencer_if #(.ADDR_W(3), .NUM_ROWS(6), .MAX_BURST(8)) b6 ();

  row_select_sequencer #(.ADDR_W(3), .NUM_ROWS(8), .MAX_BURST(8)) dut8 (
    .clk (clk), .rst (rst), .bus (b8)
  );
  row_select_sequencer #(.ADDR_W(3), .NUM_ROWS(6), .MAX_BURST(8)) dut6 (
    .clk (clk), .rst (rst), .bus (b6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Packed compare: {decoded, current, row_valid, busy, done, addr_err}.
  task automatic ex(input string tag, input bit six, input logic [7:0] dec,
                    input logic [2:0] cur, input logic rv, input logic bsy,
                    input logic dn, input logic er);
    logic [31:0] o, e;
    if (six)
      o = {17'd0, 2'b00, b6.decoded_address, b6.current_address,
           b6.row_valid, b6.busy, b6.done, b6.addr_err};
    else
      o = {17'd0, b8.decoded_address, b8.current_address,
           b8.row_valid, b8.busy, b8.done, b8.addr_err};
    e = {17'd0, dec, cur, rv, bsy, dn, er};
    check(tag, o, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req8(input logic [2:0] a, input logic [3:0] l);
    b8.req = 1'b1; b8.start_address = a; b8.burst_len = l;
  endtask

  task automatic req6(input logic [2:0] a, input logic [3:0] l);
    b6.req = 1'b1; b6.start_address = a; b6.burst_len = l;
  endtask

  initial begin
    b8.req = 1'b0; b8.start_address = '0; b8.burst_len = '0; b8.stall = 1'b0;
    b6.req = 1'b0; b6.start_address = '0; b6.burst_len = '0; b6.stall = 1'b0;

    // Reset state
    step(); step();
    ex("reset8", 0, 8'h00, 0, 0, 0, 0, 0);
    ex("reset6", 1, 8'h00, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    step();
    ex("idle", 0, 8'h00, 0, 0, 0, 0, 0);

    // Single row, address 5
    req8(3'd5, 4'd1);
    step(); b8.req = 1'b0;
    ex("single_row", 0, 8'h20, 5, 1, 1, 0, 0);
    step(); ex("single_fin", 0, 8'h00, 0, 0, 1, 1, 0);
    step(); ex("single_idle", 0, 8'h00, 0, 0, 0, 0, 0);

    // Wrap: 6,7,0,1
    req8(3'd6, 4'd4);
    step(); b8.req = 1'b0;
    ex("wrap_r6", 0, 8'h40, 6, 1, 1, 0, 0);
    step(); ex("wrap_r7", 0, 8'h80, 7, 1, 1, 0, 0);
    step(); ex("wrap_r0", 0, 8'h01, 0, 1, 1, 0, 0);
    step(); ex("wrap_r1", 0, 8'h02, 1, 1, 1, 0, 0);
    step(); ex("wrap_fin", 0, 8'h00, 0, 0, 1, 1, 0);
    step(); ex("wrap_idle", 0, 8'h00, 0, 0, 0, 0, 0);

    // Stall on row 3, req while busy ignored (also through FINISH)
    req8(3'd2, 4'd3);
    step();
    ex("stall_r2", 0, 8'h04, 2, 1, 1, 0, 0);
    req8(3'd7, 4'd1);
    step(); ex("stall_r3", 0, 8'h08, 3, 1, 1, 0, 0);
    b8.stall = 1'b1;
    step(); ex("stall_h1", 0, 8'h08, 3, 1, 1, 0, 0);
    step(); ex("stall_h2", 0, 8'h08, 3, 1, 1, 0, 0);
    b8.stall = 1'b0;
    step(); ex("stall_r4", 0, 8'h10, 4, 1, 1, 0, 0);
    step(); ex("stall_fin", 0, 8'h00, 0, 0, 1, 1, 0);
    step(); ex("stall_noq", 0, 8'h00, 0, 0, 0, 0, 0);
    b8.req = 1'b0;
    step(); ex("stall_idle", 0, 8'h00, 0, 0, 0, 0, 0);

    // Range on 6-row instance: 7 and 6 rejected, then 5 len 2 wraps to 0
    req6(3'd7, 4'd1);
    step(); b6.req = 1'b0;
    ex("range7_fin", 1, 8'h00, 0, 0, 1, 1, 1);
    step(); ex("range7_sticky", 1, 8'h00, 0, 0, 0, 0, 1);
    req6(3'd6, 4'd3);
    step(); b6.req = 1'b0;
    ex("range6_fin", 1, 8'h00, 0, 0, 1, 1, 1);
    step(); ex("range6_idle", 1, 8'h00, 0, 0, 0, 0, 1);
    req6(3'd5, 4'd2);
    step(); b6.req = 1'b0;
    ex("range_r5", 1, 8'h20, 5, 1, 1, 0, 0);
    step(); ex("range_r0", 1, 8'h01, 0, 1, 1, 0, 0);
    step(); ex("range_fin", 1, 8'h00, 0, 0, 1, 1, 0);
    step(); ex("range_idle", 1, 8'h00, 0, 0, 0, 0, 0);

    // Clamp: len 0 -> 1 row
    req8(3'd3, 4'd0);
    step(); b8.req = 1'b0;
    ex("len0_r3", 0, 8'h08, 3, 1, 1, 0, 0);
    step(); ex("len0_fin", 0, 8'h00, 0, 0, 1, 1, 0);
    step(); ex("len0_idle", 0, 8'h00, 0, 0, 0, 0, 0);

    // Clamp: len 15 -> 8 rows from 4
    req8(3'd4, 4'd15);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] r;
      step(); b8.req = 1'b0;
      r = 3'(4 + i);
      ex($sformatf("len15_row%0d", i), 0, 8'h01 << r, r, 1, 1, 0, 0);
    end
    step(); ex("len15_fin", 0, 8'h00, 0, 0, 1, 1, 0);
    step(); ex("len15_idle", 0, 8'h00, 0, 0, 0, 0, 0);

    // Async reset on the third row of a 5-row burst
    req8(3'd0, 4'd5);
    step(); b8.req = 1'b0;
    ex("rst_r0", 0, 8'h01, 0, 1, 1, 0, 0);
    step(); ex("rst_r1", 0, 8'h02, 1, 1, 1, 0, 0);
    step(); ex("rst_r2", 0, 8'h04, 2, 1, 1, 0, 0);
    #2 rst = 1'b1;
    #1 ex("rst_async", 0, 8'h00, 0, 0, 0, 0, 0);
    step(); ex("rst_held", 0, 8'h00, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    step(); ex("rst_nodone1", 0, 8'h00, 0, 0, 0, 0, 0);
    step(); ex("rst_nodone2", 0, 8'h00, 0, 0, 0, 0, 0);

    // Resume after reset
    req8(3'd1, 4'd1);
    step(); b8.req = 1'b0;
    ex("resume_r1", 0, 8'h02, 1, 1, 1, 0, 0);
    step(); ex("resume_fin", 0, 8'h00, 0, 0, 1, 1, 0);
    step(); ex("resume_idle", 0, 8'h00, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
